key_pulse_gen: RTL and testbench

Input conditioner that turns a raw, asynchronous, bouncing key/switch level into a clean single-cycle count-enable pulse per press. It sits directly upstream of the 4-bit event counter: `pulse` drives the counter's increment input, so one physical press advances the count by exactly one. It also exports the debounced level for status display.

---
 rtl/key_pulse_pkg.sv | 7 +
 rtl/key_pulse_gen_if.sv | 9 +
 rtl/key_pulse_gen_sync_2ff.sv | 14 +
 rtl/key_pulse_gen.sv | 74 +++++++
 tb/tb_key_pulse_gen.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg: shared FSM state encoding and default parameters for key_pulse_gen.
package key_pulse_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, HELD = 2'd2, RELEASE = 2'd3} state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_DELAY_DEF = 500;
  localparam int REPEAT_PERIOD_DEF = 100;
endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw key input and conditioned pulse/level/busy outputs.
interface key_pulse_gen_if;
  logic key_in;
  logic pulse;
  logic level;
  logic busy;
  modport master (output key_in, input pulse, level, busy);
  modport slave (input key_in, output pulse, level, busy);
endinterface

// File: rtl/key_pulse_gen_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a raw asynchronous input, async reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_q, r_meta} <= 2'b00;
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounces a raw key into a one-cycle count-enable pulse per press.
// Define KEY_REPEAT_EN to add auto-repeat pulses while the key stays held.
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input logic clk,
  input logic rst_n,
  key_pulse_gen_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  state_t r_state;
  state_t w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic r_pulse;
  logic w_pulse_nxt;
  logic w_key_s;
  logic w_last;
  logic w_rep_fire;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.key_in), .o_q(w_key_s));
  assign w_last = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_key_s ? ARM : IDLE;
      ARM:     w_next = !w_key_s ? IDLE : (w_last ? HELD : ARM);
      HELD:    w_next = w_key_s ? HELD : RELEASE;
      RELEASE: w_next = w_key_s ? HELD : (w_last ? IDLE : RELEASE);
      default: w_next = IDLE;
    endcase
    w_cnt_nxt = (w_next == r_state && (r_state == ARM || r_state == RELEASE)) ? r_cnt + 1'b1 : '0;
    w_pulse_nxt = (r_state == ARM && w_next == HELD) || w_rep_fire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
`ifdef KEY_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  logic [RW-1:0] r_rep_cnt;
  logic r_rep_on;
  logic w_rep_last;
  logic w_stay_held;
  // r_rep_on selects the period once the initial delay has elapsed
  assign w_rep_last = r_rep_cnt == (r_rep_on ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  assign w_stay_held = r_state == HELD && w_next == HELD;
  assign w_rep_fire = w_stay_held && w_rep_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rep_cnt <= '0;
      r_rep_on <= 1'b0;
    end else begin
      r_rep_cnt <= (!w_stay_held || w_rep_last) ? '0 : r_rep_cnt + 1'b1;
      r_rep_on <= w_stay_held && (r_rep_on || w_rep_last);
    end
`else
  localparam int unused_rep = REPEAT_DELAY + REPEAT_PERIOD;
  assign w_rep_fire = 1'b0;
`endif
  assign bus.pulse = r_pulse;
  assign bus.level = r_state == HELD || r_state == RELEASE;
  assign bus.busy = r_state == ARM || r_state == RELEASE;
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: random and directed stimulus checked every cycle against a run-length key model.
module tb_key_pulse_gen;
  localparam int D = 16;
  localparam int RD = 500;
  localparam int RP = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_pulse_gen_if bus ();
  key_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int since = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  int level_cnt = 0;
  int last_pulse = -1;
  int last_fall = -1;
  logic [3:0] down_cnt = 4'd0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // model: level flips once D+1 consecutive synchronized samples disagree with it
  bit m_s1, m_s2, m_level, m_pulse, m_prev;
  int m_run, m_age;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      {m_s1, m_s2, m_level, m_pulse, m_prev} = '0;
      m_run = 0;
      m_age = 0;
      since = 0;
      chk("rst_out", int'({bus.pulse, bus.level, bus.busy}), 0);
    end else begin
      chk("pulse", int'(bus.pulse), int'(m_pulse));
      chk("level", int'(bus.level), int'(m_level));
      chk("busy", int'(bus.busy), int'(m_run != 0));
      if (bus.pulse === 1'b1) begin
        pulse_cnt++;
        down_cnt++;
        last_pulse = since;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.level === 1'b1) level_cnt++;
      if (m_prev && bus.level === 1'b0) last_fall = since;
      m_prev = bus.level === 1'b1;
      begin
        bit smp;
        smp = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.key_in;
        m_pulse = 1'b0;
        if (smp != m_level) begin
          m_run++;
          m_age = 0;
          if (m_run == D + 1) begin
            m_level = smp;
            m_run = 0;
            m_pulse = smp;
          end
        end else begin
          if (m_level && m_run == 0) begin
            m_age++;
`ifdef KEY_REPEAT_EN
            if (m_age >= RD && (m_age - RD) % RP == 0) m_pulse = 1'b1;
`endif
          end else m_age = 0;
          m_run = 0;
        end
      end
      since++;
    end
  end
  initial begin
    int p0, b0, l0, e0;
    logic [3:0] d0;
    bus.key_in = 1'b1;
    tick(3);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    tick(40);
    chk("t1_pulses", pulse_cnt - p0, 1);
    chk("t1_edge", last_pulse, D + 3);
    chk("t1_level", int'(bus.level), 1);
    bus.key_in = 1'b0;
    tick(40);
    p0 = pulse_cnt; b0 = busy_cnt; l0 = level_cnt;
    bus.key_in = 1'b1;
    tick(5);
    bus.key_in = 1'b0;
    tick(30);
    chk("glitch_pulses", pulse_cnt - p0, 0);
    chk("glitch_level", level_cnt - l0, 0);
    chk("glitch_busy", busy_cnt - b0, 5);
    p0 = pulse_cnt;
    bus.key_in = 1'b1;
    tick(30);
    for (int i = 0; i < 3; i++) begin
      bus.key_in = 1'b0;
      tick(4);
      bus.key_in = 1'b1;
      tick(4);
    end
    bus.key_in = 1'b0;
    e0 = since;
    tick(40);
    chk("bounce_pulses", pulse_cnt - p0, 1);
    chk("bounce_fall", last_fall - e0, D + 3);
    d0 = down_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.key_in = 1'b1;
      tick(25);
      bus.key_in = 1'b0;
      tick(25);
    end
    chk("counter10", int'(4'(down_cnt - d0)), int'(4'b1010));
    p0 = pulse_cnt;
    bus.key_in = 1'b1;
    tick(8);
    chk("arm_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arm_rst_busy", int'(bus.busy), 0);
    tick(3);
    chk("arm_rst_pulses", pulse_cnt - p0, 0);
    rst_n = 1'b1;
    tick(40);
    chk("requal_pulses", pulse_cnt - p0, 1);
    chk("requal_level", int'(bus.level), 1);
    rst_n = 1'b0;
    #1;
    chk("held_rst_level", int'(bus.level), 0);
    tick(2);
    bus.key_in = 1'b0;
    p0 = pulse_cnt;
    rst_n = 1'b1;
    tick(30);
    chk("held_rst_pulses", pulse_cnt - p0, 0);
    chk("held_rst_level2", int'(bus.level), 0);
    p0 = pulse_cnt;
    bus.key_in = 1'b1;
    tick(16 + 500 + 250);
    bus.key_in = 1'b0;
    tick(40);
`ifdef KEY_REPEAT_EN
    chk("repeat_pulses", pulse_cnt - p0, 4);
`else
    chk("repeat_pulses", pulse_cnt - p0, 1);
`endif
    for (int i = 0; i < 150; i++) begin
      bus.key_in = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 40));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
